// File: rtl/inp_capture_pkg.sv
// ============================================================================
// Module      : inp_capture_pkg
// Description : Shared types and constants for the switch/button input path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inp_capture_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } cap_state_t;

    // Roughly 0.5 ms of stable level at a 100 MHz clock.
    localparam int unsigned c_DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int unsigned c_DEBOUNCE_CYCLES_SIM     = 4;

endpackage

`default_nettype wire

// File: rtl/inp_capture_btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : Synchronizes and debounces an active-low push button.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import inp_capture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_n_btn,
    output logic o_pressed,
    output logic o_press_pulse
);

    localparam int unsigned         c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0]  c_CNT_TERM = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_pressed;
    logic                   r_pressed_q;
    logic                   w_btn_s;

    // Idle level of the button is high, so the chain resets to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_n_btn};
        end
    end

    assign w_btn_s = ~r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_pressed   <= 1'b0;
            r_pressed_q <= 1'b0;
        end else begin
            r_pressed_q <= r_pressed;
            if (w_btn_s == r_pressed) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_TERM) begin
                r_cnt     <= '0;
                r_pressed <= ~r_pressed;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign o_pressed     = r_pressed;
    assign o_press_pulse = r_pressed & ~r_pressed_q;

endmodule

`default_nettype wire

// File: rtl/inp_capture.sv
// ============================================================================
// Module      : inp_capture
// Description : Latches the switch word on each debounced button press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inp_capture
    import inp_capture_pkg::*;
#(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             n_btn,
    input  logic             rd,
    output logic [WIDTH-1:0] inpval,
    output logic             valid,
    output logic             overrun,
    output logic             pressed
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sw_sync;
    logic [WIDTH-1:0]                  r_inpval;
    logic                              r_overrun;
    cap_state_t                        r_state;
    cap_state_t                        w_state_next;
    logic                              w_press_pulse;
    logic                              w_capture;
    logic                              w_set_ovr;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_btn_debounce (
        .clk           (clock),
        .rst           (reset),
        .i_n_btn       (n_btn),
        .o_pressed     (pressed),
        .o_press_pulse (w_press_pulse)
    );

    // Switches are quasi-static; per-bit synchronization is sufficient.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sw_sync <= '0;
        end else begin
            r_sw_sync <= {r_sw_sync[SYNC_STAGES-2:0], sw};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY:   if (w_press_pulse)        w_state_next = FULL;
            FULL:    if (rd && !w_press_pulse) w_state_next = EMPTY;
            default: w_state_next = EMPTY;
        endcase
    end

    // A press while FULL replaces the word only when the old one is read that cycle.
    always_comb begin
        w_capture = 1'b0;
        w_set_ovr = 1'b0;
        case (r_state)
            EMPTY: w_capture = w_press_pulse;
            FULL: begin
                w_capture = w_press_pulse & rd;
                w_set_ovr = w_press_pulse & ~rd;
            end
            default: begin
                w_capture = 1'b0;
                w_set_ovr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inpval  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_capture) begin
                r_inpval <= r_sw_sync[SYNC_STAGES-1];
            end
            if (rd) begin
                r_overrun <= 1'b0;
            end else if (w_set_ovr) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign inpval  = r_inpval;
    assign valid   = (r_state == FULL);
    assign overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_inp_capture.sv
// ============================================================================
// Module      : tb_inp_capture
// Description : Directed bench for inp_capture with an expected-word queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inp_capture;
    import inp_capture_pkg::*;

    localparam int unsigned c_WIDTH = 16;

    logic               clock;
    logic               reset;
    logic [c_WIDTH-1:0] sw;
    logic               n_btn;
    logic               rd;
    logic [c_WIDTH-1:0] inpval;
    logic               valid;
    logic               overrun;
    logic               pressed;

    int                 n_pass;
    int                 n_total;
    logic [c_WIDTH-1:0] exp_q [$];
    logic               seen_valid;

    inp_capture #(
        .WIDTH           (c_WIDTH),
        .DEBOUNCE_CYCLES (c_DEBOUNCE_CYCLES_SIM),
        .SYNC_STAGES     (2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .sw      (sw),
        .n_btn   (n_btn),
        .rd      (rd),
        .inpval  (inpval),
        .valid   (valid),
        .overrun (overrun),
        .pressed (pressed)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Waits a bounded number of cycles for valid, then scores the word.
    task automatic wait_and_score(input string tag, input int bound);
        int k;
        k = 0;
        while (valid !== 1'b1 && k < bound) begin
            tick(1);
            k++;
        end
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check({tag, "_word"}, 32'(inpval), 32'(exp_q.pop_front()));
    endtask

    task automatic read_pulse();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        sw      = '0;
        n_btn   = 1'b1;
        rd      = 1'b0;
        tick(2);
        check("rst_inpval",  32'(inpval),  32'h0);
        check("rst_valid",   32'(valid),   32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_pressed", 32'(pressed), 32'h0);
        reset = 1'b0;
        tick(2);

        // Clean press with exact latency
        sw = 16'h00A5;
        exp_q.push_back(16'h00A5);
        n_btn = 1'b0;
        tick(5);
        check("clean_pressed_e5", 32'(pressed), 32'h0);
        tick(1);
        check("clean_pressed_e6", 32'(pressed), 32'h1);
        check("clean_valid_e6",   32'(valid),   32'h0);
        tick(1);
        check("clean_valid_e7", 32'(valid), 32'h1);
        check("clean_word_e7",  32'(inpval), 32'(exp_q.pop_front()));
        read_pulse();
        check("clean_rd_valid",  32'(valid),  32'h0);
        check("clean_rd_inpval", 32'(inpval), 32'h00A5);
        n_btn = 1'b1;
        tick(8);
        check("release_pressed", 32'(pressed), 32'h0);
        check("release_valid",   32'(valid),   32'h0);

        // Bounce rejection
        sw = 16'hBEEF;
        seen_valid = 1'b0;
        repeat (5) begin
            n_btn = 1'b0;
            for (int i = 0; i < 3; i++) begin tick(1); seen_valid |= valid; end
            n_btn = 1'b1;
            tick(1);
            seen_valid |= valid;
        end
        check("bounce_no_valid", 32'(seen_valid), 32'h0);
        exp_q.push_back(16'hBEEF);
        n_btn = 1'b0;
        wait_and_score("bounce_capture", 20);
        read_pulse();
        tick(10);
        check("bounce_single_capture", 32'(valid), 32'h0);
        n_btn = 1'b1;
        tick(8);

        // Overrun
        sw = 16'h1234;
        exp_q.push_back(16'h1234);
        n_btn = 1'b0;
        wait_and_score("ovr_first", 20);
        sw = 16'h5678;
        n_btn = 1'b1;
        tick(8);
        n_btn = 1'b0;
        tick(8);
        check("ovr_flag",   32'(overrun), 32'h1);
        check("ovr_inpval", 32'(inpval),  32'h1234);
        check("ovr_valid",  32'(valid),   32'h1);
        read_pulse();
        check("ovr_rd_valid",   32'(valid),   32'h0);
        check("ovr_rd_overrun", 32'(overrun), 32'h0);
        n_btn = 1'b1;
        tick(8);

        // Press aligned with read while FULL
        sw = 16'h1111;
        exp_q.push_back(16'h1111);
        n_btn = 1'b0;
        wait_and_score("simul_first", 20);
        n_btn = 1'b1;
        tick(8);
        sw = 16'h2222;
        exp_q.push_back(16'h2222);
        n_btn = 1'b0;
        tick(6);
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
        check("simul_valid",   32'(valid),   32'h1);
        check("simul_overrun", 32'(overrun), 32'h0);
        check("simul_sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("simul_word", 32'(inpval), 32'(exp_q.pop_front()));
        tick(1);
        check("simul_hold_valid", 32'(valid), 32'h1);
        read_pulse();
        n_btn = 1'b1;
        tick(8);

        // Idle reads while EMPTY
        for (int i = 0; i < 3; i++) begin read_pulse(); tick(1); end
        check("idle_valid",   32'(valid),   32'h0);
        check("idle_overrun", 32'(overrun), 32'h0);
        check("idle_inpval",  32'(inpval),  32'h2222);

        // Reset while FULL with the button held through release
        sw = 16'h3333;
        exp_q.push_back(16'h3333);
        n_btn = 1'b0;
        wait_and_score("full_pre_rst", 20);
        reset = 1'b1;
        #1;
        check("rst_full_valid",   32'(valid),   32'h0);
        check("rst_full_inpval",  32'(inpval),  32'h0);
        check("rst_full_pressed", 32'(pressed), 32'h0);
        check("rst_full_overrun", 32'(overrun), 32'h0);
        tick(2);
        sw = 16'h4444;
        exp_q.push_back(16'h4444);
        reset = 1'b0;
        tick(6);
        check("held_pressed_e6", 32'(pressed), 32'h1);
        check("held_valid_e6",   32'(valid),   32'h0);
        tick(1);
        check("held_valid_e7", 32'(valid), 32'h1);
        check("held_word_e7",  32'(inpval), 32'(exp_q.pop_front()));
        read_pulse();

        // Reset during a release debounce
        n_btn = 1'b1;
        tick(4);
        check("mid_deb_pressed", 32'(pressed), 32'h1);
        reset = 1'b1;
        #1;
        check("rst_deb_pressed", 32'(pressed), 32'h0);
        tick(2);
        reset = 1'b0;
        tick(8);
        check("post_rst_pressed", 32'(pressed), 32'h0);
        check("post_rst_valid",   32'(valid),   32'h0);
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
